// File: rtl/deque_drv_pkg.sv
// Shared definitions for the dual-deque command driver.
// Holds the command opcodes, the driver FSM state encoding and the
// data byte returned when a POP targets an empty deque.
package deque_drv_pkg;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;

  localparam logic [7:0] POP_EMPTY_DATA = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    GETD,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/deque_drv_rsp_slot.sv
// Single-entry response holding register.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   load             capture load_data/load_err and raise rsp_valid
//   load_data[7:0]   response byte to hold
//   load_err         error flag to hold
//   rsp_ready        consumer accepts the held response
//   rsp_valid        a response is held
//   rsp_data[7:0]    held response byte (stable while rsp_valid)
//   rsp_err          held error flag (stable while rsp_valid)
module deque_drv_rsp_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_err,
  input  logic       rsp_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  logic       valid_reg;
  logic [7:0] data_reg;
  logic       err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= 8'h00;
      err_reg   <= 1'b0;
    end else begin
      if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= load_data;
        err_reg   <= load_err;
      end else if (valid_reg && rsp_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = valid_reg;
  assign rsp_data  = data_reg;
  assign rsp_err   = err_reg;

endmodule

// File: rtl/deque_cmd_driver.sv
// Byte-command initiator for the dual-deque block.
// Accepts command bytes (a PUSH is followed by its data byte), issues
// single-cycle push/pop strobes with deque/end selects, captures popped
// data POP_LAT cycles after the pop strobe and returns result bytes.
// Optional feature macro: DEQUE_DRV_PUSH_ACK_EN
//   defined   : every PUSH returns a response (pushed byte, err=1 if full);
//               ovf is tied 0
//   undefined : PUSH never responds; push-to-full sets sticky ovf, cleared
//               by STATUS or reset
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data    command byte channel
//   rsp_valid/rsp_ready/rsp_data    response byte channel, rsp_err flag
//   dq_deque_sel, dq_end_sel        deque and end selects to dual_deque
//   dq_push, dq_pop, dq_wdata       strobes and write data to dual_deque
//   dq_rdata                        read data from dual_deque
//   dq_d0/d1_empty/full             deque status flags
//   ovf                             sticky push-to-full flag
module deque_cmd_driver
  import deque_drv_pkg::*;
#(
  parameter int POP_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       dq_deque_sel,
  output logic       dq_end_sel,
  output logic       dq_push,
  output logic       dq_pop,
  output logic [7:0] dq_wdata,
  input  logic [7:0] dq_rdata,
  input  logic       dq_d0_empty,
  input  logic       dq_d0_full,
  input  logic       dq_d1_empty,
  input  logic       dq_d1_full,
  output logic       ovf
);

  state_t     state_reg, state_next;
  logic [7:0] cmd_reg;
  logic [7:0] wdata_reg;
  logic [1:0] cnt_reg;
  logic       cmd_ready_reg;

  logic       handshake;
  logic [1:0] op;
  logic       sel_empty, sel_full;
  logic [7:0] status_byte;
  logic       load;
  logic [7:0] load_data;
  logic       load_err;
`ifndef DEQUE_DRV_PUSH_ACK_EN
  logic       ovf_reg;
  logic       ovf_set, ovf_clr;
`endif

  assign handshake   = cmd_valid && cmd_ready_reg;
  assign op          = cmd_reg[7:6];
  assign sel_empty   = cmd_reg[5] ? dq_d1_empty : dq_d0_empty;
  assign sel_full    = cmd_reg[5] ? dq_d1_full  : dq_d0_full;
  assign status_byte = {4'b0000, dq_d1_full, dq_d1_empty, dq_d0_full, dq_d0_empty};

  // cmd_ready is registered from the next state so it is low while in reset
  // and during the first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cmd_reg       <= 8'h00;
      wdata_reg     <= 8'h00;
      cnt_reg       <= 2'd0;
      cmd_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == IDLE) || (state_next == GETD);
      if (state_reg == IDLE && handshake) cmd_reg <= cmd_data;
      if (state_reg == GETD && handshake) wdata_reg <= cmd_data;
      // cnt_reg counts cycles elapsed since the pop strobe.
      if (state_reg == ISSUE) cnt_reg <= 2'd1;
      else if (state_reg == WAIT) cnt_reg <= cnt_reg + 2'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    dq_push    = 1'b0;
    dq_pop     = 1'b0;
    load       = 1'b0;
    load_data  = 8'h00;
    load_err   = 1'b0;
`ifndef DEQUE_DRV_PUSH_ACK_EN
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (handshake) state_next = (cmd_data[7:6] == OP_PUSH) ? GETD : ISSUE;
      end
      GETD: begin
        if (handshake) state_next = ISSUE;
      end
      ISSUE: begin
        case (op)
          OP_PUSH: begin
            dq_push = !sel_full;
`ifdef DEQUE_DRV_PUSH_ACK_EN
            load       = 1'b1;
            load_data  = wdata_reg;
            load_err   = sel_full;
            state_next = RESP;
`else
            ovf_set    = sel_full;
            state_next = IDLE;
`endif
          end
          OP_POP: begin
            if (sel_empty) begin
              load       = 1'b1;
              load_data  = POP_EMPTY_DATA;
              load_err   = 1'b1;
              state_next = RESP;
            end else begin
              dq_pop = 1'b1;
              if (POP_LAT == 0) begin
                load       = 1'b1;
                load_data  = dq_rdata;
                state_next = RESP;
              end else begin
                state_next = WAIT;
              end
            end
          end
          OP_STATUS: begin
            load       = 1'b1;
            load_data  = status_byte;
`ifndef DEQUE_DRV_PUSH_ACK_EN
            ovf_clr    = 1'b1;
`endif
            state_next = RESP;
          end
          default: begin
            load       = 1'b1;
            load_data  = cmd_reg;
            load_err   = 1'b1;
            state_next = RESP;
          end
        endcase
      end
      WAIT: begin
        if (cnt_reg == 2'(POP_LAT)) begin
          load       = 1'b1;
          load_data  = dq_rdata;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Selects only carry the latched command while a strobe is being issued
  // or its read data is pending.
  assign dq_deque_sel = (state_reg == ISSUE || state_reg == WAIT) ? cmd_reg[5] : 1'b0;
  assign dq_end_sel   = (state_reg == ISSUE || state_reg == WAIT) ? cmd_reg[4] : 1'b0;
  assign dq_wdata     = dq_push ? wdata_reg : 8'h00;
  assign cmd_ready    = cmd_ready_reg;

`ifdef DEQUE_DRV_PUSH_ACK_EN
  assign ovf = 1'b0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_reg <= 1'b0;
    else if (ovf_set) ovf_reg <= 1'b1;
    else if (ovf_clr) ovf_reg <= 1'b0;
  end
  assign ovf = ovf_reg;
`endif

  deque_drv_rsp_slot u_rsp_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_err  (load_err),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_deque_cmd_driver.sv
module tb_deque_cmd_driver;

  logic clk = 1'b0;
  logic rst;
  logic model_clr;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       cmd_valid [4];
  logic       cmd_ready [4];
  logic [7:0] cmd_data  [4];
  logic       rsp_valid [4];
  logic       rsp_ready [4];
  logic [7:0] rsp_data  [4];
  logic       rsp_err   [4];
  logic       dq_deque_sel [4];
  logic       dq_end_sel   [4];
  logic       dq_push   [4];
  logic       dq_pop    [4];
  logic [7:0] dq_wdata  [4];
  logic [7:0] dq_rdata  [4];
  logic       d0e [4];
  logic       d0f [4];
  logic       d1e [4];
  logic       d1f [4];
  logic       ovf [4];

  // One driver per POP_LAT value, each with its own dual-deque model.
  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    deque_cmd_driver #(.POP_LAT(gi)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid[gi]),
      .cmd_ready    (cmd_ready[gi]),
      .cmd_data     (cmd_data[gi]),
      .rsp_valid    (rsp_valid[gi]),
      .rsp_ready    (rsp_ready[gi]),
      .rsp_data     (rsp_data[gi]),
      .rsp_err      (rsp_err[gi]),
      .dq_deque_sel (dq_deque_sel[gi]),
      .dq_end_sel   (dq_end_sel[gi]),
      .dq_push      (dq_push[gi]),
      .dq_pop       (dq_pop[gi]),
      .dq_wdata     (dq_wdata[gi]),
      .dq_rdata     (dq_rdata[gi]),
      .dq_d0_empty  (d0e[gi]),
      .dq_d0_full   (d0f[gi]),
      .dq_d1_empty  (d1e[gi]),
      .dq_d1_full   (d1f[gi]),
      .ovf          (ovf[gi])
    );

    logic [7:0] mem [2][16];
    int         cnt [2];
    logic [7:0] hold;
    logic [7:0] peek;

    always_comb begin
      peek = 8'h00;
      if (cnt[dq_deque_sel[gi]] > 0) begin
        if (dq_end_sel[gi]) peek = mem[dq_deque_sel[gi]][0];
        else peek = mem[dq_deque_sel[gi]][4'(cnt[dq_deque_sel[gi]] - 1)];
      end
    end

    // end_sel=1 is the front (index 0), end_sel=0 the back.
    always @(posedge clk) begin
      if (model_clr) begin
        cnt[0] <= 0;
        cnt[1] <= 0;
        hold   <= 8'h00;
      end else if (dq_push[gi] && cnt[dq_deque_sel[gi]] < 16) begin
        if (dq_end_sel[gi]) begin
          for (int i = 1; i < 16; i++) mem[dq_deque_sel[gi]][i] <= mem[dq_deque_sel[gi]][i-1];
          mem[dq_deque_sel[gi]][0] <= dq_wdata[gi];
        end else begin
          mem[dq_deque_sel[gi]][4'(cnt[dq_deque_sel[gi]])] <= dq_wdata[gi];
        end
        cnt[dq_deque_sel[gi]] <= cnt[dq_deque_sel[gi]] + 1;
      end else if (dq_pop[gi] && cnt[dq_deque_sel[gi]] > 0) begin
        hold <= peek;
        if (dq_end_sel[gi])
          for (int i = 0; i < 15; i++) mem[dq_deque_sel[gi]][i] <= mem[dq_deque_sel[gi]][i+1];
        cnt[dq_deque_sel[gi]] <= cnt[dq_deque_sel[gi]] - 1;
      end
    end

    assign dq_rdata[gi] = dq_pop[gi] ? peek : hold;
    assign d0e[gi] = (cnt[0] == 0);
    assign d0f[gi] = (cnt[0] == 16);
    assign d1e[gi] = (cnt[1] == 0);
    assign d1f[gi] = (cnt[1] == 16);
  end

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec;
  int   n_err;
  int   acc_cyc;
  int   n_push [4];
  int   n_pop  [4];
  logic [7:0] last_wd [4];
  logic last_ps [4];
  logic last_pe [4];
  logic last_os [4];
  logic last_oe [4];
  logic seen [4];
  int   first_cyc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input int k, input logic [7:0] d, input logic e);
    exp_t x;
    x.k = 2'(k);
    x.d = d;
    x.e = e;
    exp_q.push_back(x);
  endtask

  // Must be entered just after a falling edge.
  task automatic send(input int k, input logic [7:0] b);
    int t;
    t = 0;
    cmd_data[k]  = b;
    cmd_valid[k] = 1'b1;
    while (!cmd_ready[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("cmd_ready_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid[k] = 1'b0;
  endtask

  task automatic do_push(input int k, input logic [7:0] c, input logic [7:0] b, input logic full);
`ifdef DEQUE_DRV_PUSH_ACK_EN
    expect_rsp(k, b, full);
`else
    if (full) n_vec += 0;
`endif
    send(k, c);
    send(k, b);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready[k]), 32'd0);
    chk({tag, "_rsp"}, {22'd0, rsp_valid[k], rsp_err[k], rsp_data[k]}, 32'd0);
    chk({tag, "_dq"}, {20'd0, dq_deque_sel[k], dq_end_sel[k], dq_push[k], dq_pop[k], dq_wdata[k]}, 32'd0);
    chk({tag, "_ovf"}, 32'(ovf[k]), 32'd0);
  endtask

  // Sampled 2 time units after the falling edge so inputs changed on that
  // edge are already stable; the following rising edge acts on the same values.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        if (dq_push[k]) begin
          n_push[k]++;
          last_wd[k] = dq_wdata[k];
          last_ps[k] = dq_deque_sel[k];
          last_pe[k] = dq_end_sel[k];
        end
        if (dq_pop[k]) begin
          n_pop[k]++;
          last_os[k] = dq_deque_sel[k];
          last_oe[k] = dq_end_sel[k];
        end
        if (rsp_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          first_cyc[k] = cyc;
        end
        if (rsp_valid[k] && rsp_ready[k]) begin
          seen[k] = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {22'd0, 2'(k), rsp_err[k], rsp_data[k]}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_inst", 32'(k), 32'(e.k));
            chk("rsp_data", 32'(rsp_data[k]), 32'(e.d));
            chk("rsp_err", 32'(rsp_err[k]), 32'(e.e));
            $display("rsp inst=%0d data=%02h err=%0b", k, rsp_data[k], rsp_err[k]);
          end
        end
      end
    end
  endtask

  initial begin
    int p, q;
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 4; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_data[k]  = 8'h00;
      rsp_ready[k] = 1'b1;
      n_push[k] = 0;
      n_pop[k]  = 0;
      seen[k]   = 1'b0;
      first_cyc[k] = 0;
    end
    rst = 1'b1;
    model_clr = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk_zero(k, "reset");
    rst = 1'b0;
    model_clr = 1'b0;
    @(negedge clk);

    // 1: STATUS after reset
    p = n_push[1]; q = n_pop[1];
    expect_rsp(1, 8'h05, 1'b0);
    send(1, 8'h00);
    p = p; drain();
    chk("status_latency", 32'(first_cyc[1] - acc_cyc), 32'd2);
    chk("status_no_strobe", 32'(n_push[1] - p + n_pop[1] - q), 32'd0);

    // 2: PUSH A5 then POP, for every POP_LAT
    for (int k = 0; k < 4; k++) begin
      p = n_push[k]; q = n_pop[k];
      do_push(k, 8'h50, 8'hA5, 1'b0);
      drain();
      chk("push_count", 32'(n_push[k] - p), 32'd1);
      chk("push_wdata", 32'(last_wd[k]), 32'hA5);
      chk("push_sel", {30'd0, last_ps[k], last_pe[k]}, 32'b01);
      expect_rsp(k, 8'hA5, 1'b0);
      send(k, 8'h90);
      drain();
      chk("pop_latency", 32'(first_cyc[k] - acc_cyc), 32'(k + 2));
      chk("pop_count", 32'(n_pop[k] - q), 32'd1);
      chk("pop_sel", {30'd0, last_os[k], last_oe[k]}, 32'b01);
      $display("pop_lat=%0d push/pop A5 done", k);
    end

    // 3: POP on empty deque 0
    q = n_pop[1];
    expect_rsp(1, 8'h00, 1'b1);
    send(1, 8'h80);
    drain();
    chk("empty_pop_no_strobe", 32'(n_pop[1] - q), 32'd0);

    // 4: fill deque 0, then push to full
    p = n_push[1];
    for (int i = 0; i < 16; i++) do_push(1, 8'h40, 8'(8'h10 + i), 1'b0);
    drain();
    chk("fill_count", 32'(n_push[1] - p), 32'd16);
    chk("ovf_before_full", 32'(ovf[1]), 32'd0);
    do_push(1, 8'h40, 8'hEE, 1'b1);
    drain();
    chk("full_no_strobe", 32'(n_push[1] - p), 32'd16);
`ifdef DEQUE_DRV_PUSH_ACK_EN
    chk("ovf_tied", 32'(ovf[1]), 32'd0);
`else
    chk("ovf_set", 32'(ovf[1]), 32'd1);
`endif
    expect_rsp(1, 8'h06, 1'b0);
    send(1, 8'h00);
    drain();
    chk("ovf_cleared", 32'(ovf[1]), 32'd0);

    // 5: back-pressure on a POP response
    do_push(3, 8'h40, 8'h3C, 1'b0);
    drain();
    rsp_ready[3] = 1'b0;
    expect_rsp(3, 8'h3C, 1'b0);
    send(3, 8'h80);
    p = 0;
    while (!rsp_valid[3] && p < 50) begin
      @(negedge clk);
      p++;
    end
    if (p >= 50) chk("bp_rsp_timeout", 32'd0, 32'd1);
    q = n_pop[3];
    repeat (5) begin
      chk("bp_hold", {22'd0, rsp_valid[3], rsp_err[3], rsp_data[3]}, {22'd0, 1'b1, 1'b0, 8'h3C});
      chk("bp_cmd_ready", 32'(cmd_ready[3]), 32'd0);
      chk("bp_no_strobe", {30'd0, dq_push[3], dq_pop[3]}, 32'd0);
      @(negedge clk);
    end
    chk("bp_pop_count", 32'(n_pop[3] - q), 32'd0);
    rsp_ready[3] = 1'b1;
    drain();

    // 6: reset while waiting for popped data, then illegal op
    do_push(2, 8'h60, 8'h77, 1'b0);
    drain();
    q = n_pop[2];
    send(2, 8'hA0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk_zero(k, "midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_pop_count", 32'(n_pop[2] - q), 32'd1);
    chk("midrst_no_rsp", 32'(rsp_valid[2]), 32'd0);
    expect_rsp(2, 8'hC3, 1'b1);
    send(2, 8'hC3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
